// File: rtl/sm_sqrt_seq.sv
// sm_sqrt_seq: multi-cycle unsigned integer square root for the CPU datapath.
// Restoring digit-by-digit algorithm, one root bit per CALC cycle, MSB first,
// no multipliers. Constant latency of WIDTH/2 CALC cycles plus one DONE cycle.
// Optional feature: define SM_SQRT_REMAINDER_EN to add the 'rem' output
// (operand - result^2), which updates and holds together with 'result'.

module sm_sqrt_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] operand,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
`ifdef SM_SQRT_REMAINDER_EN
   ,
   output logic [WIDTH/2:0] rem
`endif
);

   localparam int HALF = WIDTH / 2;
   localparam int CW   = $clog2(HALF) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } stateT;

   stateT             state;
   logic [WIDTH-1:0]  radicand;
   logic [HALF+1:0]   partial;
   logic [HALF-1:0]   root;
   logic [CW-1:0]     iterCount;

   logic [1:0]        pairBits;
   logic [HALF+1:0]   trial;
   logic [HALF+1:0]   subtrahend;
   logic              trialFits;
   logic [HALF+1:0]   nextPartial;
   logic [HALF-1:0]   nextRoot;

   // One restoring step: bring down the next bit pair and try to subtract 4*root+1.
   // Between steps the partial remainder never exceeds HALF bits, so the top two
   // register bits are always zero there; folding them into the compare keeps the
   // whole register observable without changing the arithmetic.
   always_comb begin
      pairBits    = radicand[WIDTH-1:WIDTH-2];
      trial       = {partial[HALF-1:0], pairBits};
      subtrahend  = {root, 2'b01};
      trialFits   = (partial[HALF+1:HALF] != 2'b00) || (trial >= subtrahend);
      nextPartial = trial;
      nextRoot    = {root[HALF-2:0], 1'b0};
      if (trialFits) begin
         nextPartial = trial - subtrahend;
         nextRoot    = {root[HALF-2:0], 1'b1};
      end
   end

   // Control FSM and datapath registers; result (and rem) load only on CALC->DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         radicand  <= '0;
         partial   <= '0;
         root      <= '0;
         iterCount <= '0;
         result    <= '0;
`ifdef SM_SQRT_REMAINDER_EN
         rem       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  radicand  <= operand;
                  partial   <= '0;
                  root      <= '0;
                  iterCount <= '0;
                  state     <= CALC;
               end
            end
            CALC: begin
               radicand  <= {radicand[WIDTH-3:0], 2'b00};
               partial   <= nextPartial;
               root      <= nextRoot;
               iterCount <= iterCount + CW'(1);
               if (iterCount == LAST_ITER) begin
                  result <= {{HALF{1'b0}}, nextRoot};
`ifdef SM_SQRT_REMAINDER_EN
                  rem    <= nextPartial[HALF:0];
`endif
                  state  <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status decode; stall is gated by rst_n so a held start cannot stall the CPU during reset.
   always_comb begin
      busy  = (state == CALC);
      done  = (state == DONE);
      stall = ((state == IDLE) && start && rst_n) || (state == CALC);
   end

endmodule

// File: tb/tb_sm_sqrt_seq.sv
// tb_sm_sqrt_seq: self-checking bench for sm_sqrt_seq (WIDTH=32).
// A behavioural model tracks what the outputs must be each cycle; a single
// compare process checks them on every falling edge. Directed cases pin
// literal results, then randomized operands exercise the arithmetic.

module tb_sm_sqrt_seq;

   localparam int WIDTH = 32;
   localparam int HALF  = WIDTH / 2;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] operand;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
`ifdef SM_SQRT_REMAINDER_EN
   logic [HALF:0]    rem;
`endif

   int total = 0;
   int bad   = 0;

   sm_sqrt_seq #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .operand (operand),
      .stall   (stall),
      .busy    (busy),
      .done    (done),
      .result  (result)
`ifdef SM_SQRT_REMAINDER_EN
      ,
      .rem     (rem)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Floor square root by greedy bit search with plain multiplication.
   function automatic longint unsigned isqrtModel(input longint unsigned v);
      longint unsigned r = 0;
      longint unsigned t;
      for (int b = HALF - 1; b >= 0; b--) begin
         t = r | (longint'(1) << b);
         if (t * t <= v) r = t;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 = idle, 1 = computing, 2 = done cycle.
   int              mPhase  = 0;
   int              mLeft   = 0;
   longint unsigned mOp     = 0;
   longint unsigned mResult = 0;
   longint unsigned mRem    = 0;

   // Advance the model on every rising edge, and clear it when reset asserts.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mPhase  = 0;
         mLeft   = 0;
         mResult = 0;
         mRem    = 0;
      end else begin
         case (mPhase)
            0: if (start) begin
               mPhase = 1;
               mLeft  = HALF;
               mOp    = operand;
            end
            1: begin
               mLeft--;
               if (mLeft == 0) begin
                  mPhase  = 2;
                  mResult = isqrtModel(mOp);
                  mRem    = mOp - mResult * mResult;
               end
            end
            default: mPhase = 0;
         endcase
      end
   end

   // Compare all outputs against the model on every falling edge.
   always @(negedge clk) begin
      checkOutput("busy", busy, (mPhase == 1));
      checkOutput("done", done, (mPhase == 2));
      checkOutput("stall", stall, rst_n && ((mPhase == 0 && start) || mPhase == 1));
      checkOutput("result", result, mResult);
`ifdef SM_SQRT_REMAINDER_EN
      checkOutput("rem", rem, mRem);
`endif
   end

   // Launch one request with start held until done, optionally changing operand mid-flight.
   task automatic applyStimulus(input logic [WIDTH-1:0] op, input logic [WIDTH-1:0] op2,
                                input int changeAt, input longint unsigned expRes,
                                input longint unsigned expRem, input string tag);
      bit seen = 0;
      longint unsigned r;
      @(posedge clk);
      #2;
      start   = 1'b1;
      operand = op;
      for (int k = 1; k <= HALF + 6 && !seen; k++) begin
         @(negedge clk);
         if (changeAt != 0 && k == changeAt) operand = op2;
         if (done) begin
            seen = 1;
            r = result;
            checkOutput({tag, " latency"}, k, HALF + 2);
            checkOutput({tag, " result"}, r, expRes);
            checkOutput({tag, " bounds"}, (r * r <= op) && ((r + 1) * (r + 1) > op), 1);
`ifdef SM_SQRT_REMAINDER_EN
            checkOutput({tag, " rem"}, rem, expRem);
`endif
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("[TB] FAIL %s timeout: no done within %0d cycles (expected %0d)", tag, HALF + 6, HALF + 2);
      end
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   initial begin
      int doneCount;
      int firstDone;
      int secondDone;
      logic [WIDTH-1:0] rnd;
      longint unsigned r;

      rst_n   = 1'b0;
      start   = 1'b1;
      operand = 32'd5;

      checkOutput("pin sqrt16", isqrtModel(16), 4);
      checkOutput("pin sqrtMax", isqrtModel(64'hFFFF_FFFF), 65535);
      checkOutput("pin sqrt99", isqrtModel(99), 9);
      checkOutput("pin sqrt1e6", isqrtModel(1000000), 1000);

      // Reset state with start held high.
      repeat (3) @(negedge clk);
      checkOutput("reset stall", stall, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset result", result, 0);
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("no launch after reset", busy, 0);

      // Directed cases.
      applyStimulus(32'd16, 32'd16, 0, 4, 0, "sq16");
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 65535, 131070, "allOnes");
      applyStimulus(32'd0, 32'd0, 0, 0, 0, "zero");
      applyStimulus(32'd1, 32'd1, 0, 1, 0, "one");
      applyStimulus(32'd99, 32'd1000000, 5, 9, 18, "opChange");
      applyStimulus(32'd1000000, 32'd1000000, 0, 1000, 0, "million");

      // Start held continuously: one done per computation, 18 cycles apart.
      @(posedge clk);
      #2;
      start      = 1'b1;
      operand    = 32'd77;
      doneCount  = 0;
      firstDone  = 0;
      secondDone = 0;
      for (int k = 1; k <= 3 * (HALF + 2) && doneCount < 2; k++) begin
         @(negedge clk);
         if (done) begin
            doneCount++;
            if (doneCount == 1) begin
               firstDone = k;
               checkOutput("b2b first result", result, 8);
               operand = 32'd400;
            end else begin
               secondDone = k;
               checkOutput("b2b second result", result, 20);
            end
         end
      end
      checkOutput("b2b done count", doneCount, 2);
      checkOutput("b2b gap", secondDone - firstDone, HALF + 2);
      @(posedge clk);
      #2;
      start = 1'b0;

      // Reset asserted during the 8th CALC cycle aborts the run.
      @(posedge clk);
      #2;
      start   = 1'b1;
      operand = 32'd625;
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort stall", stall, 0);
      checkOutput("abort result", result, 0);
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("abort no done", done, 0);
      applyStimulus(32'd625, 32'd625, 0, 25, 0, "restart625");

      // Randomized operands, biased toward perfect squares and their neighbours.
      for (int i = 0; i < 2500; i++) begin
         case ($urandom_range(0, 3))
            0: rnd = $urandom_range(0, 1000);
            1: begin
               r   = $urandom_range(1, 65535);
               rnd = WIDTH'(r * r - longint'($urandom_range(0, 1)));
            end
            2: begin
               r   = $urandom_range(0, 65535);
               rnd = WIDTH'(r * r + 2 * r);
            end
            default: rnd = $urandom;
         endcase
         r = isqrtModel(rnd);
         applyStimulus(rnd, $urandom, (i % 3 == 0) ? 6 : 0, r, rnd - r * r, "random");
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
